// File: rtl/skolem_pkg.sv
// Shared types and helpers for the bit-serial Skolem witness engine.
// Optional feature macro used by this slice: SKOLEM_SELFCHECK_EN.
package skolem_pkg;

  typedef enum logic [1:0] {
    OP_UGE = 2'd0,
    OP_UGT = 2'd1,
    OP_ULE = 2'd2,
    OP_ULT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // ugt folds its "+1" into the initial carry, so c0 can be 2
  function automatic logic [1:0] carry_init(op_e op);
    logic [1:0] c;
    unique case (op)
      OP_UGT:  c = 2'd2;
      default: c = 2'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/skolem_serial_add.sv
// One-bit serial adder slice with a 2-bit carry register.
// Carry spans 0..2 so an initial "+2" can be injected at load.
module skolem_serial_add (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [1:0] c0,
  input  logic       a,
  input  logic       b,
  output logic       sum
);

  logic [1:0] c_q;
  logic [1:0] c_d;
  logic [2:0] tot;

  always_comb begin
    tot = {2'b00, a} + {2'b00, b} + {1'b0, c_q};
    sum = tot[0];
    c_d = c_q;
    if (load) begin
      c_d = c0;
    end else if (en) begin
      c_d = tot[2:1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= 2'd0;
    end else begin
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/skolem_bvadd_cmp_inv_seq.sv
// Bit-serial Skolem witness for x in (x + s) <op> t, LSB first.
// Define SKOLEM_SELFCHECK_EN to add a one-cycle CHECK state driving out_err.
module skolem_bvadd_cmp_inv_seq
  import skolem_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_sat,
  output logic         out_err
);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   s_sh_q, s_sh_d;
  logic [W-1:0]   t_sh_q, t_sh_d;
  logic [W-1:0]   x_q, x_d;
  op_e            op_q, op_d;
  logic           ones_q, ones_d;
  logic           zero_q, zero_d;
  logic           sat_q, sat_d;

  logic accept;
  logic last;
  logic a_bit;
  logic b_bit;
  logic sum_bit;
  logic ones_fin;
  logic zero_fin;

`ifdef SKOLEM_SELFCHECK_EN
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] t_q, t_d;
  logic         err_q, err_d;
  logic [W-1:0] chk_sum;
  logic         pred;
`endif

  assign accept = in_valid & in_ready;
  assign last   = (cnt_q == CNT_W'(W - 1));
  // ule/ult both want x = -s, so the t operand is masked off
  assign a_bit  = (op_q == OP_ULE || op_q == OP_ULT) ? 1'b0 : t_sh_q[0];
  assign b_bit  = ~s_sh_q[0];

  assign ones_fin = ones_q & t_sh_q[0];
  assign zero_fin = zero_q & ~t_sh_q[0];

  skolem_serial_add u_add (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state_q == CALC),
    .c0   (carry_init(op_e'(in_op))),
    .a    (a_bit),
    .b    (b_bit),
    .sum  (sum_bit)
  );

`ifdef SKOLEM_SELFCHECK_EN
  assign chk_sum = x_q + s_q;
  always_comb begin
    pred = 1'b0;
    unique case (op_q)
      OP_UGE: pred = (chk_sum >= t_q);
      OP_UGT: pred = (chk_sum >  t_q);
      OP_ULE: pred = (chk_sum <= t_q);
      OP_ULT: pred = (chk_sum <  t_q);
      default: pred = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_sh_d   = s_sh_q;
    t_sh_d   = t_sh_q;
    x_d      = x_q;
    op_d     = op_q;
    ones_d   = ones_q;
    zero_d   = zero_q;
    sat_d    = sat_q;
`ifdef SKOLEM_SELFCHECK_EN
    s_d      = s_q;
    t_d      = t_q;
    err_d    = err_q;
`endif
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          s_sh_d  = in_s;
          t_sh_d  = in_t;
          op_d    = op_e'(in_op);
          ones_d  = 1'b1;
          zero_d  = 1'b1;
`ifdef SKOLEM_SELFCHECK_EN
          s_d     = in_s;
          t_d     = in_t;
          err_d   = 1'b0;
`endif
        end
      end
      CALC: begin
        x_d    = {sum_bit, x_q[W-1:1]};
        s_sh_d = s_sh_q >> 1;
        t_sh_d = t_sh_q >> 1;
        ones_d = ones_fin;
        zero_d = zero_fin;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last) begin
          unique case (op_q)
            OP_UGT:  sat_d = ~ones_fin;
            OP_ULT:  sat_d = ~zero_fin;
            default: sat_d = 1'b1;
          endcase
`ifdef SKOLEM_SELFCHECK_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef SKOLEM_SELFCHECK_EN
        err_d = sat_q & ~pred;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_sh_q  <= '0;
      t_sh_q  <= '0;
      x_q     <= '0;
      op_q    <= OP_UGE;
      ones_q  <= 1'b1;
      zero_q  <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_sh_q  <= s_sh_d;
      t_sh_q  <= t_sh_d;
      x_q     <= x_d;
      op_q    <= op_d;
      ones_q  <= ones_d;
      zero_q  <= zero_d;
      sat_q   <= sat_d;
    end
  end

`ifdef SKOLEM_SELFCHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      t_q   <= '0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      t_q   <= t_d;
      err_q <= err_d;
    end
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_x   = x_q;
  assign out_sat = sat_q;

endmodule

// File: tb/tb_skolem_bvadd_cmp_inv_seq.sv
// Bench for skolem_bvadd_cmp_inv_seq at W=4: table vectors,
// hold/reset corner sequences and an exhaustive sweep against brute force.
module tb_skolem_bvadd_cmp_inv_seq;

`ifdef SKOLEM_SELFCHECK_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_s;
  logic [3:0] in_t;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_x;
  logic       out_sat;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] s;
    logic [3:0] t;
    logic [3:0] x;
    logic       sat;
  } vec_t;

  typedef struct {
    logic [3:0] x;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  skolem_bvadd_cmp_inv_seq #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_t      (in_t),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_sat   (out_sat),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_query(input logic [1:0] op, input logic [3:0] s,
                          input logic [3:0] t, input logic [3:0] ex,
                          input logic es, input bit full, input int hold);
    int   n;
    bit   seen;
    exp_t e;
    string tag;
    tag = $sformatf("op%0d s%0h t%0h", op, s, t);
    sb.push_back('{x: ex, sat: es});
    @(negedge clk);
    if (full) check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_s     = s;
    in_t     = t;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout act=no_out_valid exp=out_valid", tag);
      return;
    end
    if (full) check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " x"}, 32'(out_x), 32'(e.x));
    check({tag, " sat"}, 32'(out_sat), 32'(e.sat));
    check({tag, " err"}, 32'(out_err), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold_x"}, 32'(out_x), 32'(e.x));
      check({tag, " hold_sat"}, 32'(out_sat), 32'(e.sat));
      check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (full) begin
      check({tag, " post_valid"}, 32'(out_valid), 32'd0);
      check({tag, " post_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  function automatic logic brute_sat(input logic [1:0] op,
                                     input logic [3:0] s,
                                     input logic [3:0] t);
    logic [3:0] y;
    logic       p;
    logic       any;
    any = 1'b0;
    for (int xi = 0; xi < 16; xi++) begin
      y = 4'(xi) + s;
      case (op)
        2'd0:    p = (y >= t);
        2'd1:    p = (y >  t);
        2'd2:    p = (y <= t);
        default: p = (y <  t);
      endcase
      any = any | p;
    end
    return any;
  endfunction

  function automatic logic [3:0] model_x(input logic [1:0] op,
                                         input logic [3:0] s,
                                         input logic [3:0] t);
    logic [3:0] r;
    case (op)
      2'd0:    r = t - s;
      2'd1:    r = t - s + 4'd1;
      default: r = 4'd0 - s;
    endcase
    return r;
  endfunction

  initial begin
    bit pulsed;
    vecs[0] = '{op: 2'd0, s: 4'd5, t: 4'd3,  x: 4'hE, sat: 1'b1};
    vecs[1] = '{op: 2'd1, s: 4'd2, t: 4'd7,  x: 4'd6, sat: 1'b1};
    vecs[2] = '{op: 2'd1, s: 4'd5, t: 4'd15, x: 4'd11, sat: 1'b0};
    vecs[3] = '{op: 2'd2, s: 4'd3, t: 4'd0,  x: 4'd13, sat: 1'b1};
    vecs[4] = '{op: 2'd3, s: 4'd3, t: 4'd0,  x: 4'd13, sat: 1'b0};
    vecs[5] = '{op: 2'd3, s: 4'd0, t: 4'd1,  x: 4'd0, sat: 1'b1};
    vecs[6] = '{op: 2'd0, s: 4'd0, t: 4'd0,  x: 4'd0, sat: 1'b1};
    vecs[7] = '{op: 2'd2, s: 4'd0, t: 4'd15, x: 4'd0, sat: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_s      = '0;
    in_t      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_x", 32'(out_x), 32'd0);
    check("rst out_sat", 32'(out_sat), 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_query(vecs[i].op, vecs[i].s, vecs[i].t, vecs[i].x, vecs[i].sat,
               1'b1, 0);
    end

    do_query(2'd0, 4'd5, 4'd3, 4'hE, 1'b1, 1'b1, 10);

    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_s     = 4'd9;
    in_t     = 4'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_x", 32'(out_x), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulsed = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) pulsed = 1'b1;
    end
    check("midrst no_pulse", 32'(pulsed), 32'd0);
    do_query(2'd0, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1, 0);

    for (int op = 0; op < 4; op++) begin
      for (int s = 0; s < 16; s++) begin
        for (int t = 0; t < 16; t++) begin
          do_query(2'(op), 4'(s), 4'(t), model_x(2'(op), 4'(s), 4'(t)),
                   brute_sat(2'(op), 4'(s), 4'(t)), 1'b0, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
